xy_line_drawer: RTL and testbench

Vector stroke generator for the XY spacewar display. Accepts one segment command (two endpoints plus a draw/move flag) and walks the beam along it one pixel per clock using integer Bresenham stepping. For a blank move it jumps straight to the end point and dwells for settling. Sits directly upstream of the top-level pin mapping; `x_out`, `y_out` and `beam` feed the X/Y DAC and Z-blank pins.

---
 rtl/xy_line_drawer.sv | 136 +++++++++++++
 tb/tb_xy_line_drawer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/xy_line_drawer.sv
// XY vector stroke generator: Bresenham walk for lit strokes, jump-and-dwell for blank moves.
// All outputs are registered; reset is asynchronous active-high and abandons any stroke.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for start; done may pulse here for one cycle
//  ST_LINE   | beam lit, stepping one pixel per clock toward (x_end, y_end)
//  ST_SETTLE | beam blanked at move target, dwell counter running down
module xy_line_drawer #(
    parameter int W      = 8,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         draw,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         beam,
    output logic         busy,
    output logic         done
);

    localparam int EW = W + 2;
    localparam logic [3:0] DWELL_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LINE, ST_SETTLE} state_t;

    state_t               state;
    logic [W-1:0]         x_end, y_end;
    logic signed [EW-1:0] dx, dy, err;
    logic                 sx_neg, sy_neg;
    logic [3:0]           dwell;

    logic [W-1:0]         adx, ady;
    logic signed [EW-1:0] dx_init, dy_init, err_init;
    logic signed [EW-1:0] e2, err_next;
    logic                 step_x, step_y, at_end;

    always_comb begin
        adx      = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        ady      = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        dx_init  = $signed({2'b00, adx});
        dy_init  = -$signed({2'b00, ady});
        err_init = dx_init + dy_init;
    end

    // Both axis updates are evaluated against the same e2 so diagonal steps happen in one clock.
    always_comb begin
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        err_next = err;
        if (step_x)
            err_next = err_next + dy;
        if (step_y)
            err_next = err_next + dx;
        at_end   = (x_out == x_end) && (y_out == y_end);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            x_out  <= '0;
            y_out  <= '0;
            beam   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            x_end  <= '0;
            y_end  <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            dwell  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        x_end <= x1;
                        y_end <= y1;
                        if (draw) begin
                            x_out  <= x0;
                            y_out  <= y0;
                            beam   <= 1'b1;
                            dx     <= dx_init;
                            dy     <= dy_init;
                            err    <= err_init;
                            sx_neg <= (x1 < x0);
                            sy_neg <= (y1 < y0);
                            state  <= ST_LINE;
                        end else begin
                            x_out <= x1;
                            y_out <= y1;
                            beam  <= 1'b0;
                            dwell <= DWELL_LOAD;
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_LINE: begin
                    if (at_end) begin
                        beam  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        err <= err_next;
                        if (step_x)
                            x_out <= sx_neg ? (x_out - 1'b1) : (x_out + 1'b1);
                        if (step_y)
                            y_out <= sy_neg ? (y_out - 1'b1) : (y_out + 1'b1);
                    end
                end
                ST_SETTLE: begin
                    if (dwell == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        dwell <= dwell - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xy_line_drawer.sv
// Scoreboard bench for xy_line_drawer: stimulus queues cycle-stamped expected samples,
// a negedge monitor pops and compares whenever the DUT reports busy or done.
module tb_xy_line_drawer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       draw = 1'b0;
    logic [7:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [7:0] x_out, y_out;
    logic       beam, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string      name;
        int         cyc;
        logic [7:0] x;
        logic [7:0] y;
        logic       beam;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];

    xy_line_drawer #(.W(8), .SETTLE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .draw  (draw),
        .x0    (x0),
        .y0    (y0),
        .x1    (x1),
        .y1    (y1),
        .x_out (x_out),
        .y_out (y_out),
        .beam  (beam),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the DUT reports activity must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (busy || done)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d got x=%0d y=%0d beam=%0d busy=%0d done=%0d",
                         cyc, x_out, y_out, beam, busy, done);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || x_out !== e.x || y_out !== e.y ||
                    beam !== e.beam || busy !== e.busy || done !== e.done) begin
                    errors++;
                    $display("FAIL %s got cyc=%0d x=%0d y=%0d beam=%0d busy=%0d done=%0d expected cyc=%0d x=%0d y=%0d beam=%0d busy=%0d done=%0d",
                             e.name, cyc, x_out, y_out, beam, busy, done,
                             e.cyc, e.x, e.y, e.beam, e.busy, e.done);
                end
            end
        end
    end

    task automatic push(input string name, input int c, input int x, input int y,
                        input logic b, input logic bz, input logic d);
        exp_t e;
        e.name = name; e.cyc = c; e.x = 8'(x); e.y = 8'(y);
        e.beam = b; e.busy = bz; e.done = d;
        q.push_back(e);
    endtask

    task automatic pt(input string name, input int c, input int x, input int y);
        push(name, c, x, y, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic fin(input string name, input int c, input int x, input int y);
        push(name, c, x, y, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic issue(input logic d, input int ax, input int ay, input int bx, input int by);
        draw = d; x0 = 8'(ax); y0 = 8'(ay); x1 = 8'(bx); y1 = 8'(by);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending expectations, expected 0", name, q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (x_out !== 8'd0 || y_out !== 8'd0 || beam !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s got x=%0d y=%0d beam=%0d busy=%0d done=%0d expected all 0",
                     name, x_out, y_out, beam, busy, done);
        end
    endtask

    initial begin
        int c0, c1;
        #3;
        check_zero("reset_state");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("after_reset_idle");

        // Horizontal line (0,0)->(3,0)
        c0 = cyc;
        pt("horiz_p0", c0 + 1, 0, 0);
        pt("horiz_p1", c0 + 2, 1, 0);
        pt("horiz_p2", c0 + 3, 2, 0);
        pt("horiz_p3", c0 + 4, 3, 0);
        fin("horiz_done", c0 + 5, 3, 0);
        issue(1'b1, 0, 0, 3, 0);
        drain("horiz");

        // Steep line (10,10)->(12,15)
        c0 = cyc;
        pt("steep_p0", c0 + 1, 10, 10);
        pt("steep_p1", c0 + 2, 10, 11);
        pt("steep_p2", c0 + 3, 11, 12);
        pt("steep_p3", c0 + 4, 11, 13);
        pt("steep_p4", c0 + 5, 12, 14);
        pt("steep_p5", c0 + 6, 12, 15);
        fin("steep_done", c0 + 7, 12, 15);
        issue(1'b1, 10, 10, 12, 15);
        drain("steep");

        // Reverse diagonal (5,5)->(2,2)
        c0 = cyc;
        pt("revdiag_p0", c0 + 1, 5, 5);
        pt("revdiag_p1", c0 + 2, 4, 4);
        pt("revdiag_p2", c0 + 3, 3, 3);
        pt("revdiag_p3", c0 + 4, 2, 2);
        fin("revdiag_done", c0 + 5, 2, 2);
        issue(1'b1, 5, 5, 2, 2);
        drain("revdiag");

        // Single point (7,9)->(7,9)
        c0 = cyc;
        pt("point_p0", c0 + 1, 7, 9);
        fin("point_done", c0 + 2, 7, 9);
        issue(1'b1, 7, 9, 7, 9);
        drain("point");

        // Move to (200,40), ignored start on cycle 2, back-to-back draw on cycle 5
        c0 = cyc;
        push("move_c1", c0 + 1, 200, 40, 1'b0, 1'b1, 1'b0);
        push("move_c2", c0 + 2, 200, 40, 1'b0, 1'b1, 1'b0);
        push("move_c3", c0 + 3, 200, 40, 1'b0, 1'b1, 1'b0);
        push("move_c4", c0 + 4, 200, 40, 1'b0, 1'b1, 1'b0);
        fin("move_done", c0 + 5, 200, 40);
        push("move_done_beam", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        void'(q.pop_back());
        issue(1'b0, 1, 2, 200, 40);
        wait_cycle(c0 + 2);
        issue(1'b1, 9, 9, 50, 60);
        wait_cycle(c0 + 5);
        c1 = cyc;
        pt("b2b_p0", c1 + 1, 200, 40);
        pt("b2b_p1", c1 + 2, 201, 41);
        pt("b2b_p2", c1 + 3, 202, 41);
        fin("b2b_done", c1 + 4, 202, 41);
        issue(1'b1, 200, 40, 202, 41);
        drain("move_b2b");

        // Reset during cycle 3 of the steep line: no done pulse may follow
        c0 = cyc;
        pt("rst_steep_p0", c0 + 1, 10, 10);
        pt("rst_steep_p1", c0 + 2, 10, 11);
        issue(1'b1, 10, 10, 12, 15);
        wait_cycle(c0 + 3);
        #2;
        rst = 1'b1;
        #1;
        check_zero("reset_mid_stroke");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_zero("reset_held");
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_zero("no_done_after_reset");
        drain("reset_mid");

        // Fresh stroke after reset (3,3)->(0,3)
        c0 = cyc;
        pt("post_rst_p0", c0 + 1, 3, 3);
        pt("post_rst_p1", c0 + 2, 2, 3);
        pt("post_rst_p2", c0 + 3, 1, 3);
        pt("post_rst_p3", c0 + 4, 0, 3);
        fin("post_rst_done", c0 + 5, 0, 3);
        issue(1'b1, 3, 3, 0, 3);
        drain("post_rst");

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d pending, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
